fetch_sequencer: RTL and testbench

Fetch-stage controller for the pipelined processor. It owns the PC register and sequences a variable-latency instruction memory through a req/ack handshake. It applies execute-stage redirects (PCSrcE/PCTargetE) and decode-stage stalls, and drives the IF/ID pipeline register (InstrD, PCD, PCPlus4D, ValidD). It allows a plain fetch stage to run against memories slower than one cycle without losing or duplicating instructions.

---
 rtl/fetch_sequencer.sv | 158 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns PCF, drives a variable-latency instruction memory
// over req/ack, and loads the IF/ID register under stall and redirect control.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallD,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD,
   output logic        fetch_busy,
   output logic [1:0]  fsmState
);

   // Memory handshake: imem_req/imem_addr come from registered state only. Once
   // imem_req rises it stays high with a stable address until imem_ack is seen on
   // a rising edge; imem_ack and imem_rdata are ignored whenever imem_req is low.

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] REQ     = 2'd1;
   localparam logic [1:0] HOLD    = 2'd2;
   localparam logic [1:0] DISCARD = 2'd3;

   logic [1:0]  state;
   logic [1:0]  stateNext;
   logic [31:0] pcF;
   logic [31:0] pcNext;
   logic [31:0] pcPlus4F;
   logic [31:0] staleAddr;

   logic        skidValid;
   logic [31:0] skidInstr;
   logic [31:0] skidPc;

   logic        loadFetch;
   logic        loadSkid;
   logic        captureSkid;
   logic        clearSkid;
   logic        bubble;
   logic        latchStale;

   assign pcPlus4F   = pcF + 32'd4;
   assign imem_req   = (state == REQ) || (state == DISCARD);
   // While discarding, the outstanding request keeps its original address even
   // though PCF already holds the redirect target.
   assign imem_addr  = (state == DISCARD) ? staleAddr : pcF;
   assign fetch_busy = imem_req;
   assign fsmState   = state;

   always_comb begin
      stateNext   = state;
      pcNext      = pcF;
      loadFetch   = 1'b0;
      loadSkid    = 1'b0;
      captureSkid = 1'b0;
      clearSkid   = 1'b0;
      bubble      = 1'b0;
      latchStale  = 1'b0;
      if (PCSrcE) begin
         pcNext     = PCTargetE;
         bubble     = 1'b1;
         clearSkid  = 1'b1;
         stateNext  = (imem_req && !imem_ack) ? DISCARD : REQ;
         latchStale = (state == REQ) && !imem_ack;
      end else begin
         case (state)
            IDLE: stateNext = REQ;
            REQ: begin
               if (imem_ack) begin
                  pcNext = pcPlus4F;
                  if (StallD) begin
                     captureSkid = 1'b1;
                     stateNext   = HOLD;
                  end else begin
                     loadFetch = 1'b1;
                  end
               end else if (!StallD) begin
                  bubble = 1'b1;
               end
            end
            HOLD: begin
               if (!StallD) begin
                  loadSkid  = 1'b1;
                  clearSkid = 1'b1;
                  stateNext = REQ;
               end
            end
            DISCARD: begin
               if (imem_ack) stateNext = REQ;
               if (!StallD) bubble = 1'b1;
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         pcF   <= RESET_PC;
      end else begin
         state <= stateNext;
         pcF   <= pcNext;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         staleAddr <= 32'd0;
      end else if (latchStale) begin
         staleAddr <= pcF;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skidValid <= 1'b0;
         skidInstr <= 32'd0;
         skidPc    <= 32'd0;
      end else if (captureSkid) begin
         skidValid <= 1'b1;
         skidInstr <= imem_rdata;
         skidPc    <= pcF;
      end else if (clearSkid) begin
         skidValid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         InstrD   <= 32'd0;
         PCD      <= 32'd0;
         PCPlus4D <= 32'd0;
         ValidD   <= 1'b0;
      end else if (bubble) begin
         ValidD <= 1'b0;
      end else if (loadFetch) begin
         InstrD   <= imem_rdata;
         PCD      <= pcF;
         PCPlus4D <= pcPlus4F;
         ValidD   <= 1'b1;
      end else if (loadSkid) begin
         InstrD   <= skidInstr;
         PCD      <= skidPc;
         PCPlus4D <= skidPc + 32'd4;
         ValidD   <= skidValid;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed cycle table for fetch_sequencer plus hand sequences for
// mid-request reset and discarded-address corner cases.
module tb_fetch_sequencer;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_REQ     = 2'd1;
   localparam logic [1:0] S_HOLD    = 2'd2;
   localparam logic [1:0] S_DISCARD = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic        StallD;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        ValidD;
   logic        fetch_busy;
   logic [1:0]  fsmState;

   int nAssert = 0;
   int nFail   = 0;

   fetch_sequencer #(.RESET_PC(32'h00000000)) dut (
      .clk(clk), .rst(rst), .StallD(StallD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .ValidD(ValidD), .fetch_busy(fetch_busy), .fsmState(fsmState)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        src;
      logic [31:0] tgt;
      logic        ack;
      logic        expReq;
      logic [31:0] expAddr;
      logic        expValid;
      logic [31:0] expPcD;
      logic [31:0] expP4;
      logic [1:0]  expState;
   } vec_t;

   vec_t vecs[32];

   // Instruction word the memory returns for an address: rotate left by 8.
   function automatic logic [31:0] instrOf(input logic [31:0] a);
      return {a[23:0], a[31:24]};
   endfunction

   function automatic vec_t mk(input logic r, input logic s, input logic b,
                               input logic [31:0] t, input logic a, input logic q,
                               input logic [31:0] ad, input logic v,
                               input logic [31:0] pd, input logic [31:0] p4,
                               input logic [1:0] st);
      vec_t x;
      x.rst = r; x.stall = s; x.src = b; x.tgt = t; x.ack = a;
      x.expReq = q; x.expAddr = ad; x.expValid = v; x.expPcD = pd; x.expP4 = p4;
      x.expState = st;
      return x;
   endfunction

   task automatic chk(input string name, input int row, input logic [31:0] got,
                      input logic [31:0] exp);
      nAssert++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s (row %0d): got %h, expected %h", name, row, got, exp);
      end
   endtask

   task automatic chkAll(input int row, input logic req, input logic [31:0] addr,
                         input logic v, input logic [31:0] pd, input logic [31:0] p4,
                         input logic [31:0] instr, input logic [1:0] st);
      chk("imem_req", row, {31'd0, imem_req}, {31'd0, req});
      chk("fetch_busy", row, {31'd0, fetch_busy}, {31'd0, req});
      chk("imem_addr", row, imem_addr, addr);
      chk("ValidD", row, {31'd0, ValidD}, {31'd0, v});
      chk("PCD", row, PCD, pd);
      chk("PCPlus4D", row, PCPlus4D, p4);
      chk("InstrD", row, InstrD, instr);
      chk("state", row, {30'd0, fsmState}, {30'd0, st});
   endtask

   initial begin
      rst = 1'b1; StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0;
      imem_ack = 1'b0; imem_rdata = 32'd0;

      //           rst stl src target        ack | req addr          v  PCD           PCPlus4D      state
      vecs[0]  = mk(1, 0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        32'h0,        S_IDLE);
      vecs[1]  = mk(0, 0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        32'h0,        S_IDLE);
      vecs[2]  = mk(0, 0, 0, 32'h0,        1,   1, 32'h0,        0, 32'h0,        32'h0,        S_REQ);
      vecs[3]  = mk(0, 0, 0, 32'h0,        1,   1, 32'h4,        1, 32'h0,        32'h4,        S_REQ);
      vecs[4]  = mk(0, 0, 0, 32'h0,        1,   1, 32'h8,        1, 32'h4,        32'h8,        S_REQ);
      vecs[5]  = mk(0, 0, 0, 32'h0,        0,   1, 32'hC,        1, 32'h8,        32'hC,        S_REQ);
      vecs[6]  = mk(0, 0, 0, 32'h0,        0,   1, 32'hC,        0, 32'h8,        32'hC,        S_REQ);
      vecs[7]  = mk(0, 0, 0, 32'h0,        0,   1, 32'hC,        0, 32'h8,        32'hC,        S_REQ);
      vecs[8]  = mk(0, 0, 0, 32'h0,        1,   1, 32'hC,        0, 32'h8,        32'hC,        S_REQ);
      vecs[9]  = mk(0, 0, 0, 32'h0,        0,   1, 32'h10,       1, 32'hC,        32'h10,       S_REQ);
      vecs[10] = mk(0, 0, 0, 32'h0,        0,   1, 32'h10,       0, 32'hC,        32'h10,       S_REQ);
      vecs[11] = mk(0, 0, 0, 32'h0,        0,   1, 32'h10,       0, 32'hC,        32'h10,       S_REQ);
      vecs[12] = mk(0, 0, 0, 32'h0,        1,   1, 32'h10,       0, 32'hC,        32'h10,       S_REQ);
      vecs[13] = mk(0, 1, 0, 32'h0,        1,   1, 32'h14,       1, 32'h10,       32'h14,       S_REQ);
      vecs[14] = mk(0, 1, 0, 32'h0,        0,   0, 32'h18,       1, 32'h10,       32'h14,       S_HOLD);
      vecs[15] = mk(0, 1, 0, 32'h0,        0,   0, 32'h18,       1, 32'h10,       32'h14,       S_HOLD);
      vecs[16] = mk(0, 0, 0, 32'h0,        0,   0, 32'h18,       1, 32'h10,       32'h14,       S_HOLD);
      vecs[17] = mk(0, 0, 0, 32'h0,        0,   1, 32'h18,       1, 32'h14,       32'h18,       S_REQ);
      vecs[18] = mk(0, 0, 1, 32'h40,       0,   1, 32'h18,       0, 32'h14,       32'h18,       S_REQ);
      vecs[19] = mk(0, 0, 0, 32'h0,        0,   1, 32'h18,       0, 32'h14,       32'h18,       S_DISCARD);
      vecs[20] = mk(0, 0, 0, 32'h0,        1,   1, 32'h18,       0, 32'h14,       32'h18,       S_DISCARD);
      vecs[21] = mk(0, 0, 0, 32'h0,        1,   1, 32'h40,       0, 32'h14,       32'h18,       S_REQ);
      vecs[22] = mk(0, 1, 1, 32'h80,       1,   1, 32'h44,       1, 32'h40,       32'h44,       S_REQ);
      vecs[23] = mk(0, 0, 0, 32'h0,        1,   1, 32'h80,       0, 32'h40,       32'h44,       S_REQ);
      vecs[24] = mk(0, 1, 0, 32'h0,        1,   1, 32'h84,       1, 32'h80,       32'h84,       S_REQ);
      vecs[25] = mk(0, 1, 1, 32'hC0,       0,   0, 32'h88,       1, 32'h80,       32'h84,       S_HOLD);
      vecs[26] = mk(0, 0, 0, 32'h0,        0,   1, 32'hC0,       0, 32'h80,       32'h84,       S_REQ);
      vecs[27] = mk(0, 0, 1, 32'hFFFFFFFC, 0,   1, 32'hC0,       0, 32'h80,       32'h84,       S_REQ);
      vecs[28] = mk(0, 1, 0, 32'h0,        1,   1, 32'hC0,       0, 32'h80,       32'h84,       S_DISCARD);
      vecs[29] = mk(0, 0, 0, 32'h0,        1,   1, 32'hFFFFFFFC, 0, 32'h80,       32'h84,       S_REQ);
      vecs[30] = mk(0, 0, 0, 32'h0,        0,   1, 32'h0,        1, 32'hFFFFFFFC, 32'h0,        S_REQ);
      vecs[31] = mk(0, 0, 0, 32'h0,        0,   1, 32'h0,        0, 32'hFFFFFFFC, 32'h0,        S_REQ);

      // Each row: check outputs left by the previous edge, then drive the next inputs.
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         chkAll(i, vecs[i].expReq, vecs[i].expAddr, vecs[i].expValid, vecs[i].expPcD,
                vecs[i].expP4, instrOf(vecs[i].expPcD), vecs[i].expState);
         rst        = vecs[i].rst;
         StallD     = vecs[i].stall;
         PCSrcE     = vecs[i].src;
         PCTargetE  = vecs[i].tgt;
         imem_ack   = vecs[i].ack;
         imem_rdata = vecs[i].ack ? instrOf(vecs[i].expAddr) : 32'hDEADBEEF;
      end

      // Redirect while the request at 0 is pending, then take the stale ack.
      @(negedge clk);
      PCSrcE = 1'b1; PCTargetE = 32'h100; imem_ack = 1'b0;
      @(negedge clk);
      chk("discard_addr", 100, imem_addr, 32'h0);
      chk("discard_state", 100, {30'd0, fsmState}, {30'd0, S_DISCARD});
      PCSrcE = 1'b0; imem_ack = 1'b1; imem_rdata = instrOf(32'h0);
      @(negedge clk);
      imem_ack = 1'b0; imem_rdata = 32'hDEADBEEF;
      chkAll(101, 1'b1, 32'h100, 1'b0, 32'hFFFFFFFC, 32'h0, instrOf(32'hFFFFFFFC), S_REQ);

      // Asynchronous reset in the middle of the outstanding request.
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chkAll(102, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, S_IDLE);
      @(negedge clk);
      rst = 1'b0;
      #1 chkAll(103, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, S_IDLE);
      @(negedge clk);
      chkAll(104, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, S_REQ);

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
